// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared 8-entry sequence table and checker state encoding
package seq_pkg;

  localparam int SEQ_LEN = 8;
  localparam logic [7:0] ACQ_BYTE = 8'hAF;

  // Common to generator and checker so the two link ends cannot diverge.
  localparam logic [7:0] SEQ [SEQ_LEN] = '{
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - acquires lock on the byte sequence and counts matches/errors
module sequence_checker
  import seq_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [7:0]       data_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] match_count,
  output logic [2:0]       exp_index
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] run_q, run_d;
  logic [3:0] loss_q, loss_d;
  logic       error_d;
  logic       err_inc, match_inc;
  logic       hit;

  assign hit = (data_in == SEQ[idx_q]);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    run_d     = run_q;
    loss_d    = loss_q;
    error_d   = 1'b0;
    err_inc   = 1'b0;
    match_inc = 1'b0;
    if (valid) begin
      case (state_q)
        HUNT: begin
          if (data_in == ACQ_BYTE) begin
            idx_d   = 3'd1;
            run_d   = 4'd1;
            loss_d  = 4'd0;
            state_d = (LOCK_COUNT == 1) ? LOCKED : SYNC;
          end else begin
            idx_d = 3'd0;
            run_d = 4'd0;
          end
        end
        SYNC: begin
          if (hit) begin
            idx_d = idx_q + 3'd1;
            run_d = run_q + 4'd1;
            if (run_q + 4'd1 >= LOCK_N) begin
              state_d = LOCKED;
              loss_d  = 4'd0;
            end
          end else if (data_in == ACQ_BYTE) begin
            // Absorbs the repeated first byte a freshly reset generator emits.
            idx_d = 3'd1;
            run_d = 4'd1;
          end else begin
            state_d = HUNT;
            idx_d   = 3'd0;
            run_d   = 4'd0;
          end
        end
        LOCKED: begin
          idx_d = idx_q + 3'd1;
          if (hit) begin
            match_inc = 1'b1;
            loss_d    = 4'd0;
          end else begin
            error_d = 1'b1;
            err_inc = 1'b1;
            loss_d  = loss_q + 4'd1;
            if (loss_q + 4'd1 >= LOSS_N) begin
              state_d = HUNT;
              idx_d   = 3'd0;
              run_d   = 4'd0;
              loss_d  = 4'd0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = 3'd0;
          run_d   = 4'd0;
          loss_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HUNT;
      idx_q   <= 3'd0;
      run_q   <= 4'd0;
      loss_q  <= 4'd0;
      error   <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      loss_q  <= loss_d;
      error   <= error_d;
      locked  <= (state_d == LOCKED);
    end
  end

  assign exp_index = idx_q;

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clear_cnt),
    .count (err_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_inc),
    .clr   (clear_cnt),
    .count (match_count)
  );

endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - randomized self-checking bench for sequence_checker
module tb_sequence_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        clear_cnt = 1'b0;

  logic        locked, error, locked_s, error_s;
  logic [15:0] err_count, match_count;
  logic [1:0]  err_count_s, match_count_s;
  logic [2:0]  exp_index, exp_index_s;

  logic [7:0] ref_seq [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

  int checks = 0;
  int errors = 0;

  // Reference model: alignment described as "run of consecutive good bytes".
  bit m_lock, m_err;
  int m_idx, m_run, m_loss, m_errc, m_matchc, m_errc_s, m_matchc_s;

  sequence_checker dut (
    .clk(clk), .reset(reset), .valid(valid), .data_in(data_in), .clear_cnt(clear_cnt),
    .locked(locked), .error(error), .err_count(err_count), .match_count(match_count),
    .exp_index(exp_index)
  );

  sequence_checker #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .valid(valid), .data_in(data_in), .clear_cnt(clear_cnt),
    .locked(locked_s), .error(error_s), .err_count(err_count_s), .match_count(match_count_s),
    .exp_index(exp_index_s)
  );

  always #5 clk = ~clk;

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : max;
  endfunction

  task automatic model_clear_all();
    m_lock = 0; m_err = 0; m_idx = 0; m_run = 0; m_loss = 0;
    m_errc = 0; m_matchc = 0; m_errc_s = 0; m_matchc_s = 0;
  endtask

  task automatic model_update(input bit v, input logic [7:0] d, input bit c);
    m_err = 0;
    if (v) begin
      if (!m_lock) begin
        if (m_run > 0 && d == ref_seq[m_idx]) begin
          m_idx = (m_idx + 1) % 8;
          m_run = m_run + 1;
        end else if (d == 8'hAF) begin
          m_idx = 1;
          m_run = 1;
        end else begin
          m_idx = 0;
          m_run = 0;
        end
        if (m_run >= LOCK_N) begin
          m_lock = 1;
          m_loss = 0;
        end
      end else begin
        if (d == ref_seq[m_idx]) begin
          m_matchc = sat_inc(m_matchc, 65535);
          m_matchc_s = sat_inc(m_matchc_s, 3);
          m_loss = 0;
        end else begin
          m_err = 1;
          m_errc = sat_inc(m_errc, 65535);
          m_errc_s = sat_inc(m_errc_s, 3);
          m_loss = m_loss + 1;
        end
        m_idx = (m_idx + 1) % 8;
        if (m_loss >= LOSS_N) begin
          m_lock = 0; m_idx = 0; m_run = 0; m_loss = 0;
        end
      end
    end
    if (c) begin
      m_errc = 0; m_matchc = 0; m_errc_s = 0; m_matchc_s = 0;
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit c);
    valid = v; data_in = d; clear_cnt = c;
    @(posedge clk);
    model_update(v, d, c);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; valid = 1'b1; data_in = 8'hAF; clear_cnt = 1'b1;
    @(posedge clk);
    model_clear_all();
    #1;
    reset = 1'b1; valid = 1'b0; clear_cnt = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b exp 0", locked); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %0b exp 0", error); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_errc got %0d exp 0", err_count); end
    checks++; if (match_count !== 16'd0) begin errors++; $display("FAIL reset_matchc got %0d exp 0", match_count); end
    checks++; if (exp_index !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", exp_index); end
  endtask

  task automatic test_clean_lock();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, ref_seq[i], 1'b0);
      checks++;
      if (locked !== (i >= 3)) begin errors++; $display("FAIL clean_locked byte%0d got %0b exp %0b", i, locked, (i >= 3)); end
      if (i == 3) begin
        checks++; if (exp_index !== 3'd4) begin errors++; $display("FAIL clean_idx_at_lock got %0d exp 4", exp_index); end
      end
    end
    checks++; if (match_count !== 16'd4) begin errors++; $display("FAIL clean_matchc got %0d exp 4", match_count); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clean_errc got %0d exp 0", err_count); end
    checks++; if (exp_index !== 3'd0) begin errors++; $display("FAIL clean_wrap got %0d exp 0", exp_index); end
  endtask

  task automatic test_double_acq();
    logic [7:0] bytes [5];
    bytes = '{8'hAF, 8'hAF, 8'hBC, 8'hE2, 8'h78};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bytes[i], 1'b0);
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL dbl_error byte%0d got %0b exp 0", i, error); end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL dbl_locked got %0b exp 1", locked); end
    checks++; if (exp_index !== 3'd4) begin errors++; $display("FAIL dbl_idx got %0d exp 4", exp_index); end
  endtask

  task automatic test_corrupt_and_loss();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, ref_seq[i], 1'b0);
    step(1'b1, 8'h00, 1'b0);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL corrupt_pulse got %0b exp 1", error); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL corrupt_errc got %0d exp 1", err_count); end
    checks++; if (exp_index !== 3'd5) begin errors++; $display("FAIL corrupt_idx got %0d exp 5", exp_index); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL corrupt_locked got %0b exp 1", locked); end
    step(1'b1, 8'hE2, 1'b0);
    checks++; if (match_count !== 16'd1) begin errors++; $display("FAIL corrupt_next_match got %0d exp 1", match_count); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL corrupt_pulse_width got %0b exp 0", error); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h55, 1'b0);
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL loss_pulse%0d got %0b exp 1", i, error); end
      checks++; if (locked !== (i < 2)) begin errors++; $display("FAIL loss_locked%0d got %0b exp %0b", i, locked, (i < 2)); end
    end
    checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL loss_errc got %0d exp 4", err_count); end
    checks++; if (exp_index !== 3'd0) begin errors++; $display("FAIL loss_idx got %0d exp 0", exp_index); end
    step(1'b1, 8'hBC, 1'b0);
    checks++; if (exp_index !== 3'd0 || locked !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL loss_ignore_bc got idx%0d lk%0b er%0b exp idx0 lk0 er0", exp_index, locked, error);
    end
    step(1'b1, 8'hAF, 1'b0);
    checks++; if (exp_index !== 3'd1) begin errors++; $display("FAIL loss_reacq got %0d exp 1", exp_index); end
  endtask

  task automatic test_valid_gaps();
    logic [2:0] held;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(0, 2) == 0) begin
        held = exp_index;
        step(1'b0, 8'($urandom), 1'b0);
        checks++; if (exp_index !== held || error !== 1'b0) begin
          errors++; $display("FAIL gap_idle got idx%0d er%0b exp idx%0d er0", exp_index, error, held);
        end
      end
      step(1'b1, ref_seq[i % 8], 1'b0);
      checks++; if (exp_index !== 3'((i + 1) % 8)) begin
        errors++; $display("FAIL gap_idx byte%0d got %0d exp %0d", i, exp_index, (i + 1) % 8);
      end
    end
    checks++; if (match_count !== 16'd12) begin errors++; $display("FAIL gap_matchc got %0d exp 12", match_count); end
  endtask

  task automatic test_clear_and_saturate();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, ref_seq[i], 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, ref_seq[m_idx], 1'b0);
    end
    checks++; if (err_count !== 16'd5) begin errors++; $display("FAIL clr_pre_errc got %0d exp 5", err_count); end
    checks++; if (err_count_s !== 2'd3) begin errors++; $display("FAIL sat_errc got %0d exp 3", err_count_s); end
    step(1'b1, ref_seq[m_idx], 1'b1);
    checks++; if (err_count !== 16'd0 || match_count !== 16'd0) begin
      errors++; $display("FAIL clr_counts got e%0d m%0d exp e0 m0", err_count, match_count);
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clr_locked got %0b exp 1", locked); end
    step(1'b1, 8'h00, 1'b0);
    reset = 1'b0; valid = 1'b1; data_in = ref_seq[m_idx];
    @(posedge clk);
    model_clear_all();
    #1;
    reset = 1'b1;
    checks++; if (locked !== 1'b0 || err_count !== 16'd0 || match_count !== 16'd0 || exp_index !== 3'd0) begin
      errors++; $display("FAIL midreset got lk%0b e%0d m%0d idx%0d exp all 0", locked, err_count, match_count, exp_index);
    end
  endtask

  task automatic test_random();
    int g = 0;
    int r;
    logic [7:0] d;
    bit v, c;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      v = 1'b1;
      if (r < 15) begin
        v = 1'b0; d = 8'($urandom);
      end else if (r < 23) begin
        d = 8'($urandom);
      end else if (r < 26) begin
        d = 8'hAF; g = 1;
      end else begin
        d = ref_seq[g]; g = (g + 1) % 8;
      end
      c = ($urandom_range(0, 99) < 2);
      step(v, d, c);
      checks++;
      if (locked !== m_lock || error !== m_err || exp_index !== 3'(m_idx)
          || err_count !== 16'(m_errc) || match_count !== 16'(m_matchc)
          || err_count_s !== 2'(m_errc_s) || match_count_s !== 2'(m_matchc_s)) begin
        errors++;
        $display("FAIL rand cyc%0d got lk%0b er%0b idx%0d e%0d m%0d es%0d ms%0d exp lk%0b er%0b idx%0d e%0d m%0d es%0d ms%0d",
                 n, locked, error, exp_index, err_count, match_count, err_count_s, match_count_s,
                 m_lock, m_err, m_idx, m_errc, m_matchc, m_errc_s, m_matchc_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_double_acq();
    test_corrupt_and_loss();
    test_valid_gaps();
    test_clear_and_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
